// File: rtl/s3_writeback_regfile.sv
// s3_writeback_regfile
//   Stage-3 writeback register plus a 2**ADDR_W-entry register file with two
//   combinational read ports and a saturating commit counter.
//
//   Ports:
//     clk, rst            clock; synchronous active-high reset
//     ALU_Out             stage-2 ALU result
//     S2_WriteSelect      stage-2 destination register index
//     S2_WriteEnable      stage-2 register-write request
//     ReadSelect1/2       read port indices from decode
//     S3_WriteData        registered writeback data
//     S3_WriteSelect      registered writeback index
//     S3_WriteEnable      registered writeback enable
//     Reg_ReadData1/2     read port data (register 0 reads 0, S3 bypass)
//     Commit_Count        saturating count of committed register writes
module s3_writeback_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ALU_Out,
    input  logic [ADDR_W-1:0] S2_WriteSelect,
    input  logic              S2_WriteEnable,
    input  logic [ADDR_W-1:0] ReadSelect1,
    input  logic [ADDR_W-1:0] ReadSelect2,
    output logic [DATA_W-1:0] S3_WriteData,
    output logic [ADDR_W-1:0] S3_WriteSelect,
    output logic              S3_WriteEnable,
    output logic [DATA_W-1:0] Reg_ReadData1,
    output logic [DATA_W-1:0] Reg_ReadData2,
    output logic [15:0]       Commit_Count
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [ADDR_W-1:0] wb_sel_q,  wb_sel_d;
    logic              wb_en_q,   wb_en_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [15:0]       commit_cnt_q, commit_cnt_d;

    logic              commit;

    // Writes to index 0 are dropped here, so register 0 is never loaded and
    // such writes are not counted.
    assign commit = wb_en_q && (wb_sel_q != '0);

    always_comb begin
        wb_data_d    = ALU_Out;
        wb_sel_d     = S2_WriteSelect;
        wb_en_d      = S2_WriteEnable;
        regs_d       = regs_q;
        commit_cnt_d = commit_cnt_q;

        if (commit) begin
            regs_d[wb_sel_q] = wb_data_q;
            if (commit_cnt_q != '1) begin
                commit_cnt_d = commit_cnt_q + 16'd1;
            end
        end

        // Reset overrides the pending commit as well as the new capture.
        if (rst) begin
            wb_data_d    = '0;
            wb_sel_d     = '0;
            wb_en_d      = 1'b0;
            commit_cnt_d = '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        wb_data_q    <= wb_data_d;
        wb_sel_q     <= wb_sel_d;
        wb_en_q      <= wb_en_d;
        regs_q       <= regs_d;
        commit_cnt_q <= commit_cnt_d;
    end

    // Read ports: index 0 first, then the not-yet-committed S3 entry, then
    // the array. Stage-2 inputs are deliberately not bypassed.
    always_comb begin
        Reg_ReadData1 = regs_q[ReadSelect1];
        if (wb_en_q && (wb_sel_q == ReadSelect1)) begin
            Reg_ReadData1 = wb_data_q;
        end
        if (ReadSelect1 == '0) begin
            Reg_ReadData1 = '0;
        end
    end

    always_comb begin
        Reg_ReadData2 = regs_q[ReadSelect2];
        if (wb_en_q && (wb_sel_q == ReadSelect2)) begin
            Reg_ReadData2 = wb_data_q;
        end
        if (ReadSelect2 == '0) begin
            Reg_ReadData2 = '0;
        end
    end

    assign S3_WriteData   = wb_data_q;
    assign S3_WriteSelect = wb_sel_q;
    assign S3_WriteEnable = wb_en_q;
    assign Commit_Count   = commit_cnt_q;

endmodule

// File: tb/tb_s3_writeback_regfile.sv
module tb_s3_writeback_regfile;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] ALU_Out;
    logic [ADDR_W-1:0] S2_WriteSelect;
    logic              S2_WriteEnable;
    logic [ADDR_W-1:0] ReadSelect1;
    logic [ADDR_W-1:0] ReadSelect2;
    logic [DATA_W-1:0] S3_WriteData;
    logic [ADDR_W-1:0] S3_WriteSelect;
    logic              S3_WriteEnable;
    logic [DATA_W-1:0] Reg_ReadData1;
    logic [DATA_W-1:0] Reg_ReadData2;
    logic [15:0]       Commit_Count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural register contents, the one write that
    // is in flight (captured but not yet committed), and the commit tally.
    logic [DATA_W-1:0] m_regs [NREGS];
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_sel;
    logic              m_en;
    int                m_cnt;

    s3_writeback_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ALU_Out        (ALU_Out),
        .S2_WriteSelect (S2_WriteSelect),
        .S2_WriteEnable (S2_WriteEnable),
        .ReadSelect1    (ReadSelect1),
        .ReadSelect2    (ReadSelect2),
        .S3_WriteData   (S3_WriteData),
        .S3_WriteSelect (S3_WriteSelect),
        .S3_WriteEnable (S3_WriteEnable),
        .Reg_ReadData1  (Reg_ReadData1),
        .Reg_ReadData2  (Reg_ReadData2),
        .Commit_Count   (Commit_Count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] sel);
        if (sel == 0) return '0;
        if (m_en && m_sel == sel) return m_data;
        return m_regs[sel];
    endfunction

    // One rising edge; model advances with the inputs presented at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
            m_data = '0; m_sel = '0; m_en = 1'b0; m_cnt = 0;
        end else begin
            if (m_en && m_sel != 0) begin
                m_regs[m_sel] = m_data;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            m_data = ALU_Out; m_sel = S2_WriteSelect; m_en = S2_WriteEnable;
        end
        #1;
    endtask

    task automatic drive_s2(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] s, input logic e);
        ALU_Out = d; S2_WriteSelect = s; S2_WriteEnable = e;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_s2($urandom, 5'd4, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        drive_s2('0, '0, 1'b0);
        n_cmp++; if (S3_WriteData !== 32'h0) begin n_fail++; $display("FAIL reset_s3_data got %h exp 0", S3_WriteData); end
        n_cmp++; if (S3_WriteSelect !== 5'h0) begin n_fail++; $display("FAIL reset_s3_sel got %h exp 0", S3_WriteSelect); end
        n_cmp++; if (S3_WriteEnable !== 1'b0) begin n_fail++; $display("FAIL reset_s3_en got %b exp 0", S3_WriteEnable); end
        n_cmp++; if (Commit_Count !== 16'h0) begin n_fail++; $display("FAIL reset_count got %h exp 0", Commit_Count); end
        for (int i = 0; i < 8; i++) begin
            ReadSelect1 = 5'($urandom); ReadSelect2 = 5'($urandom);
            #1;
            n_cmp++; if (Reg_ReadData1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 sel %0d got %h exp 0", ReadSelect1, Reg_ReadData1); end
            n_cmp++; if (Reg_ReadData2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2 sel %0d got %h exp 0", ReadSelect2, Reg_ReadData2); end
        end
    endtask

    task automatic test_basic();
        int c0;
        c0 = m_cnt;
        drive_s2(32'hDEADBEEF, 5'd5, 1'b1);
        tick();
        drive_s2('0, '0, 1'b0);
        n_cmp++; if (S3_WriteEnable !== 1'b1) begin n_fail++; $display("FAIL basic_s3_en got %b exp 1", S3_WriteEnable); end
        n_cmp++; if (S3_WriteData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_s3_data got %h exp deadbeef", S3_WriteData); end
        n_cmp++; if (S3_WriteSelect !== 5'd5) begin n_fail++; $display("FAIL basic_s3_sel got %0d exp 5", S3_WriteSelect); end
        tick();
        ReadSelect1 = 5'd5; ReadSelect2 = 5'd6;
        #1;
        n_cmp++; if (Reg_ReadData1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_reg5 got %h exp deadbeef", Reg_ReadData1); end
        n_cmp++; if (Reg_ReadData2 !== 32'h0) begin n_fail++; $display("FAIL basic_reg6 got %h exp 0", Reg_ReadData2); end
        n_cmp++; if (int'(Commit_Count) !== c0 + 1) begin n_fail++; $display("FAIL basic_count got %0d exp %0d", Commit_Count, c0 + 1); end
    endtask

    task automatic test_bypass();
        drive_s2(32'h12345678, 5'd7, 1'b1);
        tick();
        // Stage-2 now targets reg 7 with other data; reads must not see it.
        drive_s2(32'hCAFEF00D, 5'd7, 1'b0);
        ReadSelect1 = 5'd7; ReadSelect2 = 5'd7;
        #1;
        n_cmp++; if (Reg_ReadData1 !== 32'h12345678) begin n_fail++; $display("FAIL bypass_rd1 got %h exp 12345678", Reg_ReadData1); end
        n_cmp++; if (Reg_ReadData2 !== 32'h12345678) begin n_fail++; $display("FAIL bypass_rd2 got %h exp 12345678", Reg_ReadData2); end
        tick();
        drive_s2('0, '0, 1'b0);
        #1;
        n_cmp++; if (Reg_ReadData1 !== 32'h12345678) begin n_fail++; $display("FAIL bypass_commit got %h exp 12345678", Reg_ReadData1); end
    endtask

    task automatic test_reg0();
        int c0;
        c0 = m_cnt;
        drive_s2(32'hFFFFFFFF, 5'd0, 1'b1);
        tick();
        drive_s2('0, '0, 1'b0);
        ReadSelect1 = 5'd0; ReadSelect2 = 5'd0;
        #1;
        n_cmp++; if (S3_WriteData !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reg0_s3_data got %h exp ffffffff", S3_WriteData); end
        n_cmp++; if (Reg_ReadData1 !== 32'h0) begin n_fail++; $display("FAIL reg0_rd_s3 got %h exp 0", Reg_ReadData1); end
        n_cmp++; if (Reg_ReadData2 !== 32'h0) begin n_fail++; $display("FAIL reg0_rd2_s3 got %h exp 0", Reg_ReadData2); end
        tick();
        n_cmp++; if (Reg_ReadData1 !== 32'h0) begin n_fail++; $display("FAIL reg0_rd_after got %h exp 0", Reg_ReadData1); end
        n_cmp++; if (int'(Commit_Count) !== c0) begin n_fail++; $display("FAIL reg0_count got %0d exp %0d", Commit_Count, c0); end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = m_cnt;
        drive_s2(32'h1, 5'd3, 1'b1);
        tick();
        drive_s2(32'h2, 5'd3, 1'b1);
        tick();
        drive_s2('0, '0, 1'b0);
        ReadSelect1 = 5'd3;
        #1;
        n_cmp++; if (Reg_ReadData1 !== 32'h2) begin n_fail++; $display("FAIL b2b_bypass got %h exp 2", Reg_ReadData1); end
        tick();
        n_cmp++; if (Reg_ReadData1 !== 32'h2) begin n_fail++; $display("FAIL b2b_reg3 got %h exp 2", Reg_ReadData1); end
        n_cmp++; if (int'(Commit_Count) !== c0 + 2) begin n_fail++; $display("FAIL b2b_count got %0d exp %0d", Commit_Count, c0 + 2); end
    endtask

    task automatic test_reset_mid();
        drive_s2(32'hAA, 5'd9, 1'b1);
        tick();
        drive_s2(32'h55, 5'd10, 1'b1);
        rst = 1'b1;
        tick();
        ReadSelect1 = 5'd9; ReadSelect2 = 5'd5;
        #1;
        n_cmp++; if (Reg_ReadData1 !== 32'h0) begin n_fail++; $display("FAIL rstmid_reg9 got %h exp 0", Reg_ReadData1); end
        n_cmp++; if (Reg_ReadData2 !== 32'h0) begin n_fail++; $display("FAIL rstmid_reg5 got %h exp 0", Reg_ReadData2); end
        n_cmp++; if ({S3_WriteData, S3_WriteSelect, S3_WriteEnable} !== '0) begin n_fail++; $display("FAIL rstmid_s3 got %h/%0d/%b exp 0", S3_WriteData, S3_WriteSelect, S3_WriteEnable); end
        n_cmp++; if (Commit_Count !== 16'h0) begin n_fail++; $display("FAIL rstmid_count got %0d exp 0", Commit_Count); end
        rst = 1'b0;
        drive_s2('0, '0, 1'b0);
        tick();
        tick();
        n_cmp++; if (Reg_ReadData1 !== 32'h0) begin n_fail++; $display("FAIL rstmid_reg9_after got %h exp 0", Reg_ReadData1); end
        n_cmp++; if (Commit_Count !== 16'h0) begin n_fail++; $display("FAIL rstmid_count_after got %0d exp 0", Commit_Count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_s2($urandom, 5'($urandom), ($urandom_range(0, 3) != 0));
            rst = ($urandom_range(0, 49) == 0);
            ReadSelect1 = 5'($urandom); ReadSelect2 = 5'($urandom);
            tick();
            n_cmp++; if (S3_WriteData !== m_data || S3_WriteSelect !== m_sel || S3_WriteEnable !== m_en) begin
                n_fail++; $display("FAIL rand_s3 it %0d got %h/%0d/%b exp %h/%0d/%b", i, S3_WriteData, S3_WriteSelect, S3_WriteEnable, m_data, m_sel, m_en);
            end
            n_cmp++; if (int'(Commit_Count) !== m_cnt) begin n_fail++; $display("FAIL rand_count it %0d got %0d exp %0d", i, Commit_Count, m_cnt); end
            // Next S2 values presented early to confirm reads ignore them.
            drive_s2($urandom, m_sel, 1'b1);
            ReadSelect1 = ($urandom_range(0, 2) == 0) ? m_sel : 5'($urandom);
            ReadSelect2 = ($urandom_range(0, 2) == 0) ? m_sel : 5'($urandom);
            #1;
            n_cmp++; if (Reg_ReadData1 !== m_read(ReadSelect1)) begin n_fail++; $display("FAIL rand_rd1 it %0d sel %0d got %h exp %h", i, ReadSelect1, Reg_ReadData1, m_read(ReadSelect1)); end
            n_cmp++; if (Reg_ReadData2 !== m_read(ReadSelect2)) begin n_fail++; $display("FAIL rand_rd2 it %0d sel %0d got %h exp %h", i, ReadSelect2, Reg_ReadData2, m_read(ReadSelect2)); end
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_s2(32'h77, 5'd1, 1'b1);
        while (m_cnt < 16'hFFFE) begin
            drive_s2($urandom, 5'($urandom_range(1, 31)), 1'b1);
            tick();
        end
        n_cmp++; if (Commit_Count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %h exp fffe", Commit_Count); end
        for (int i = 0; i < 3; i++) begin
            drive_s2($urandom, 5'($urandom_range(1, 31)), 1'b1);
            tick();
        end
        n_cmp++; if (Commit_Count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp ffff", Commit_Count); end
        drive_s2('0, '0, 1'b0);
        tick();
        tick();
        n_cmp++; if (Commit_Count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final got %h exp ffff", Commit_Count); end
    endtask

    initial begin
        rst = 1'b1;
        drive_s2('0, '0, 1'b0);
        ReadSelect1 = '0; ReadSelect2 = '0;
        for (int i = 0; i < int'(NREGS); i++) m_regs[i] = 'x;
        m_data = 'x; m_sel = 'x; m_en = 1'bx; m_cnt = -1;
        test_reset();
        test_basic();
        test_bypass();
        test_reg0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/s3_writeback_regfile.md
S3_WRITEBACK_REGFILE -- requirements
Module: s3_writeback_regfile

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- DATA_W, 32, register and ALU data width.
- ADDR_W, 5, register index width; the file holds 2**ADDR_W registers.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset; synchronous, active-high.
- ALU_Out, in, DATA_W: stage-2 ALU result.
- S2_WriteSelect, in, ADDR_W: stage-2 destination register index.
- S2_WriteEnable, in, 1: stage-2 register-write request.
- ReadSelect1, in, ADDR_W: read port 1 index (driven by decode).
- ReadSelect2, in, ADDR_W: read port 2 index (driven by decode).
- S3_WriteData, out, DATA_W: registered writeback data.
- S3_WriteSelect, out, ADDR_W: registered writeback index.
- S3_WriteEnable, out, 1: registered writeback enable.
- Reg_ReadData1, out, DATA_W: read port 1 data.
- Reg_ReadData2, out, DATA_W: read port 2 data.
- Commit_Count, out, 16: number of committed register writes.

Function
REQ-003 On each rising clk edge with rst low, S3_WriteData, S3_WriteSelect and S3_WriteEnable SHALL load ALU_Out, S2_WriteSelect and S2_WriteEnable respectively (1-cycle latency).

REQ-004 On each rising clk edge with rst low, when S3_WriteEnable=1 and S3_WriteSelect!=0, register[S3_WriteSelect] SHALL load S3_WriteData.
- The commit therefore lands 2 edges after the stage-2 inputs are presented.

REQ-005 Register 0 SHALL never be written and SHALL always read 0.
- A write with S3_WriteSelect=0 SHALL be discarded.
- A discarded write SHALL NOT increment Commit_Count.

REQ-006 Reg_ReadDataN SHALL be combinational from ReadSelectN and current state, with this priority:
- (a) ReadSelectN=0 -> 0.
- (b) S3_WriteEnable=1 and S3_WriteSelect=ReadSelectN -> S3_WriteData (write-through bypass).
- (c) otherwise -> register[ReadSelectN].

REQ-007 Both read ports SHALL operate independently.
- Both may select the same register, including the bypassed one, in the same cycle.

REQ-008 Commit_Count SHALL increment by 1 on every edge where REQ-004 performs a write.
- It SHALL saturate at 16'hFFFF and not wrap.

REQ-009 S2 inputs SHALL be captured into S3 on every non-reset edge.
- No stall or hold input exists.
- A write pending in S3 SHALL commit even if the new S2 entry targets the same register.
- Back-to-back writes to one index SHALL leave the later value.

REQ-010 Read ports SHALL NOT reflect stage-2 inputs (no bypass from ALU_Out); only the S3 bypass of REQ-006 applies.

Reset
REQ-011 On a rising edge with rst=1, the following SHALL all become 0, overriding any pending write:
- S3_WriteData, S3_WriteSelect, S3_WriteEnable.
- Commit_Count.
- All 2**ADDR_W registers.

REQ-012 Reset asserted mid-operation SHALL discard the S3 entry; that write SHALL never commit after rst deasserts.

REQ-013 In the first cycle after reset, all read ports SHALL return 0.

Verification
REQ-014 Basic writeback and commit:
- Stimulus: reset; present ALU_Out=32'hDEADBEEF, S2_WriteSelect=5, S2_WriteEnable=1 for one cycle.
- Response: S3_WriteEnable=1 and S3_WriteData=DEADBEEF after edge 1; register[5]=DEADBEEF and Commit_Count=1 after edge 2.

REQ-015 Bypass before commit:
- Stimulus: with the S3 entry targeting reg 7 and data 32'h12345678, set ReadSelect1=7 and ReadSelect2=7 before the commit edge.
- Response: both read ports return 12345678.

REQ-016 Register 0 protection:
- Stimulus: write 32'hFFFFFFFF to reg 0 with enable=1.
- Response: Reg_ReadData1=0 with ReadSelect1=0, both in the S3 cycle and after it; Commit_Count unchanged.

REQ-017 Back-to-back writes:
- Stimulus: consecutive cycles write reg 3=32'h1, then reg 3=32'h2.
- Response: register[3]=2 after the final commit; Commit_Count increments by 2.

REQ-018 Reset mid-operation:
- Stimulus: assert rst on the edge where the S3 entry (reg 9=32'hAA) would commit.
- Response: register[9]=0; all outputs 0; reg 9 still reads 0 after rst deasserts.

REQ-019 Saturation:
- Stimulus: preload Commit_Count near 16'hFFFE through 3 more commits (forced preload or long run).
- Response: Commit_Count holds at 16'hFFFF.
